cache_kv_controller: RTL and testbench

- Downstream consumer of the OBI cache interface.
- Accepts one cache operation at a time (READ, UPSERT, DELETE) with a key and a value. Executes it against a small fully-associative key/value store held in flops, then returns success and read data.
- Interface handshake is ready/done. The interface holds its request stable until done is seen.

---
 rtl/cache_kv_controller_if.sv | 40 ++++
 rtl/cache_kv_controller.sv | 175 +++++++++++++++++
 tb/tb_cache_kv_controller.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/cache_kv_controller_if.sv
// Operation types shared by the requester and the key/value controller,
// and the request/response bundle between them.
package ctrl_types_pkg;
  typedef enum logic [1:0] {
    OP_NONE   = 2'd0,
    OP_READ   = 2'd1,
    OP_UPSERT = 2'd2,
    OP_DELETE = 2'd3
  } operation_e;
endpackage

interface cache_kv_controller_if #(
  parameter int ARCHITECTURE = 64,
  parameter int NUM_ENTRIES  = 8
);
  localparam int KEY_WIDTH   = ARCHITECTURE;
  localparam int VALUE_WIDTH = 2 * ARCHITECTURE;
  localparam int OCC_W       = $clog2(NUM_ENTRIES + 1);

  ctrl_types_pkg::operation_e operation_in;
  logic [KEY_WIDTH-1:0]       key_in;
  logic [VALUE_WIDTH-1:0]     value_in;
  logic                       ready_out;
  logic                       op_done_out;
  logic                       op_succ_out;
  logic [VALUE_WIDTH-1:0]     value_out;
  logic [OCC_W-1:0]           occupancy_out;

  // Requester side: issues operations, observes results.
  modport master (
    output operation_in, key_in, value_in,
    input  ready_out, op_done_out, op_succ_out, value_out, occupancy_out
  );

  // Controller side: consumes operations, produces results.
  modport slave (
    input  operation_in, key_in, value_in,
    output ready_out, op_done_out, op_succ_out, value_out, occupancy_out
  );
endinterface

// File: rtl/cache_kv_controller.sv
// Small fully-associative key/value store in flops. One operation at a time:
// IDLE (accept) -> LOOKUP (match/free search) -> EXEC (apply) -> DONE (pulse).
module cache_kv_controller #(
  parameter int ARCHITECTURE = 64,
  parameter int NUM_ENTRIES  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  cache_kv_controller_if.slave  bus
);
  import ctrl_types_pkg::*;

  localparam int KEY_WIDTH   = ARCHITECTURE;
  localparam int VALUE_WIDTH = 2 * ARCHITECTURE;
  localparam int IDX_W       = $clog2(NUM_ENTRIES);
  localparam int OCC_W       = $clog2(NUM_ENTRIES + 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOOKUP = 2'd1,
    ST_EXEC   = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  state_e                 state_q;
  operation_e             op_q;
  logic [KEY_WIDTH-1:0]   key_q;
  logic [VALUE_WIDTH-1:0] val_q;

  logic [NUM_ENTRIES-1:0] valid_q;
  logic [KEY_WIDTH-1:0]   key_mem [NUM_ENTRIES];
  logic [VALUE_WIDTH-1:0] val_mem [NUM_ENTRIES];

  logic                   hit_c, free_c;
  logic [IDX_W-1:0]       hit_idx_c, free_idx_c;
  logic                   hit_q, free_q;
  logic [IDX_W-1:0]       hit_idx_q, free_idx_q;

  logic                   ready_q, done_q, succ_q;
  logic [VALUE_WIDTH-1:0] value_out_q;
  logic [OCC_W-1:0]       occ_q;

  logic                   accept;

  // Only the three real operations start a transaction; NONE or any unknown
  // encoding leaves the controller idle.
  always_comb begin
    accept = 1'b0;
    if (state_q == ST_IDLE) begin
      case (bus.operation_in)
        OP_READ, OP_UPSERT, OP_DELETE: accept = 1'b1;
        default:                       accept = 1'b0;
      endcase
    end
  end

  // Search all valid slots for the latched key and all slots for a free one;
  // the descending scan leaves the lowest matching/free index.
  always_comb begin
    // NOTE: every output gets a default before the loop so no path leaves a
    // value unassigned, which would otherwise infer a latch.
    hit_c      = 1'b0;
    hit_idx_c  = '0;
    free_c     = 1'b0;
    free_idx_c = '0;
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      if (valid_q[i] && (key_mem[i] == key_q)) begin
        hit_c     = 1'b1;
        hit_idx_c = IDX_W'(i);
      end
      if (!valid_q[i]) begin
        free_c     = 1'b1;
        free_idx_c = IDX_W'(i);
      end
    end
  end

  // Control FSM, valid bits, occupancy and registered result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      op_q        <= OP_NONE;
      valid_q     <= '0;
      hit_q       <= 1'b0;
      hit_idx_q   <= '0;
      free_q      <= 1'b0;
      free_idx_q  <= '0;
      ready_q     <= 1'b1;
      done_q      <= 1'b0;
      succ_q      <= 1'b0;
      value_out_q <= '0;
      occ_q       <= '0;
    end else begin
      // NOTE: state uses non-blocking assignments so every register samples
      // pre-edge values regardless of statement order.
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            op_q    <= bus.operation_in;
            ready_q <= 1'b0;
            state_q <= ST_LOOKUP;
          end
        end
        ST_LOOKUP: begin
          hit_q      <= hit_c;
          hit_idx_q  <= hit_idx_c;
          free_q     <= free_c;
          free_idx_q <= free_idx_c;
          state_q    <= ST_EXEC;
        end
        ST_EXEC: begin
          value_out_q <= '0;
          succ_q      <= 1'b0;
          case (op_q)
            OP_READ: begin
              succ_q <= hit_q;
              if (hit_q) value_out_q <= val_mem[hit_idx_q];
            end
            OP_UPSERT: begin
              if (hit_q) begin
                succ_q <= 1'b1;
              end else if (free_q) begin
                valid_q[free_idx_q] <= 1'b1;
                occ_q               <= occ_q + OCC_W'(1);
                succ_q              <= 1'b1;
              end
            end
            OP_DELETE: begin
              if (hit_q) begin
                valid_q[hit_idx_q] <= 1'b0;
                occ_q              <= occ_q - OCC_W'(1);
                succ_q             <= 1'b1;
              end
            end
            default: ;
          endcase
          done_q  <= 1'b1;
          state_q <= ST_DONE;
        end
        ST_DONE: begin
          done_q  <= 1'b0;
          ready_q <= 1'b1;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Request latches and slot key/value contents; meaningful only alongside a
  // set valid bit.
  always_ff @(posedge clk) begin
    // NOTE: data storage has no reset; the valid bits alone define contents,
    // so resetting wide key/value arrays would buy nothing.
    if (accept) begin
      key_q <= bus.key_in;
      val_q <= bus.value_in;
    end
    if (state_q == ST_EXEC && op_q == OP_UPSERT) begin
      if (hit_q) begin
        val_mem[hit_idx_q] <= val_q;
      end else if (free_q) begin
        key_mem[free_idx_q] <= key_q;
        val_mem[free_idx_q] <= val_q;
      end
    end
  end

  assign bus.ready_out     = ready_q;
  assign bus.op_done_out   = done_q;
  assign bus.op_succ_out   = succ_q;
  assign bus.value_out     = value_out_q;
  assign bus.occupancy_out = occ_q;

endmodule

// File: tb/tb_cache_kv_controller.sv
// Bench for cache_kv_controller: directed scenarios followed by random
// operations, compared against a dictionary model of the store.
module tb_cache_kv_controller;
  import ctrl_types_pkg::*;

  localparam int ARCH = 64;
  localparam int NENT = 8;
  localparam int KW   = ARCH;
  localparam int VW   = 2 * ARCH;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  // Reference store: key -> value, capacity NENT.
  logic [VW-1:0] model [logic [KW-1:0]];

  cache_kv_controller_if #(.ARCHITECTURE(ARCH), .NUM_ENTRIES(NENT)) bus ();

  cache_kv_controller #(.ARCHITECTURE(ARCH), .NUM_ENTRIES(NENT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL global_timeout observed=running required=finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Apply one operation to the model; return expected status and read data.
  task automatic model_apply(input operation_e op, input logic [KW-1:0] k,
                             input logic [VW-1:0] v,
                             output logic exp_s, output logic [VW-1:0] exp_v);
    exp_s = 1'b0;
    exp_v = '0;
    case (op)
      OP_READ: if (model.exists(k)) begin exp_s = 1'b1; exp_v = model[k]; end
      OP_UPSERT: begin
        if (model.exists(k) || model.num() < NENT) begin
          model[k] = v;
          exp_s = 1'b1;
        end
      end
      OP_DELETE: if (model.exists(k)) begin model.delete(k); exp_s = 1'b1; end
      default: ;
    endcase
  endtask

  function automatic logic [VW-1:0] rand_val();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Issue one operation and check the full E0..E3 timeline and results.
  task automatic do_op(input string tag, input operation_e op,
                       input logic [KW-1:0] k, input logic [VW-1:0] v);
    logic          exp_s;
    logic [VW-1:0] exp_v;
    int            waited;
    waited = 0;
    while (bus.ready_out !== 1'b1 && waited < 16) begin
      @(negedge clk);
      waited++;
    end
    check({tag, "_ready_pre"}, 128'(bus.ready_out), 128'(1));
    model_apply(op, k, v, exp_s, exp_v);
    @(negedge clk);
    bus.operation_in = op;
    bus.key_in       = k;
    bus.value_in     = v;
    @(posedge clk); #1;  // E0
    bus.operation_in = operation_e'($urandom_range(0, 3));
    bus.key_in       = {$urandom(), $urandom()};
    bus.value_in     = rand_val();
    check({tag, "_ready_busy"}, 128'(bus.ready_out), 128'(0));
    @(posedge clk); #1;  // E1
    check({tag, "_done_early"}, 128'(bus.op_done_out), 128'(0));
    @(posedge clk); #1;  // E2
    check({tag, "_done"}, 128'(bus.op_done_out), 128'(1));
    check({tag, "_succ"}, 128'(bus.op_succ_out), 128'(exp_s));
    check({tag, "_value"}, 128'(bus.value_out), 128'(exp_v));
    check({tag, "_occ"}, 128'(bus.occupancy_out), 128'(model.num()));
    @(posedge clk); #1;  // E3
    bus.operation_in = OP_NONE;
    check({tag, "_done_pulse"}, 128'(bus.op_done_out), 128'(0));
    check({tag, "_ready_post"}, 128'(bus.ready_out), 128'(1));
    check({tag, "_succ_hold"}, 128'(bus.op_succ_out), 128'(exp_s));
    check({tag, "_value_hold"}, 128'(bus.value_out), 128'(exp_v));
  endtask

  initial begin
    int pulses[$];
    n_tests = 0;
    n_fail  = 0;
    rst_n            = 1'b0;
    bus.operation_in = OP_NONE;
    bus.key_in       = '0;
    bus.value_in     = '0;

    // Reset state.
    #23;
    check("rst_ready", 128'(bus.ready_out), 128'(1));
    check("rst_done", 128'(bus.op_done_out), 128'(0));
    check("rst_succ", 128'(bus.op_succ_out), 128'(0));
    check("rst_value", 128'(bus.value_out), 128'(0));
    check("rst_occ", 128'(bus.occupancy_out), 128'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // NONE is never accepted.
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("none_ready", 128'(bus.ready_out), 128'(1));
      check("none_done", 128'(bus.op_done_out), 128'(0));
    end

    // Miss, insert, read back, overwrite.
    do_op("read_miss", OP_READ, 64'h5, '0);
    do_op("ups_new", OP_UPSERT, 64'h5, 128'hAAAA);
    do_op("read_hit", OP_READ, 64'h5, '0);
    do_op("ups_over", OP_UPSERT, 64'h5, 128'h1234);
    do_op("read_over", OP_READ, 64'h5, '0);

    // Fill to capacity with keys 0..7 (key 0 is legal), then full/reuse cases.
    for (int i = 0; i < NENT; i++) do_op("fill", OP_UPSERT, 64'(i), rand_val());
    do_op("ups_full", OP_UPSERT, 64'h9, 128'h9999);
    do_op("del_3", OP_DELETE, 64'h3, '0);
    do_op("ups_reuse", OP_UPSERT, 64'h9, 128'h9999);
    do_op("read_9", OP_READ, 64'h9, '0);
    do_op("read_0", OP_READ, 64'h0, '0);
    do_op("del_absent", OP_DELETE, 64'hFF, '0);

    // Back-to-back READ held on the bus: one acceptance every 4 cycles.
    @(negedge clk);
    bus.operation_in = OP_READ;
    bus.key_in       = 64'h5;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (bus.op_done_out === 1'b1) pulses.push_back(c);
    end
    bus.operation_in = OP_NONE;
    check("thr_count", 128'(pulses.size()), 128'(10));
    for (int i = 1; i < pulses.size(); i++)
      check("thr_gap", 128'(pulses[i] - pulses[i-1]), 128'(4));

    // Reset during EXEC of an UPSERT drops the operation and empties the store.
    @(negedge clk);
    bus.operation_in = OP_UPSERT;
    bus.key_in       = 64'h77;
    bus.value_in     = 128'h7777;
    @(posedge clk); #1;  // E0
    bus.operation_in = OP_NONE;
    @(posedge clk); #1;  // E1: now in EXEC
    rst_n = 1'b0;
    #1;
    check("mid_rst_done", 128'(bus.op_done_out), 128'(0));
    check("mid_rst_occ", 128'(bus.occupancy_out), 128'(0));
    check("mid_rst_ready", 128'(bus.ready_out), 128'(1));
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      check("mid_rst_nodone", 128'(bus.op_done_out), 128'(0));
    end
    @(negedge clk);
    rst_n = 1'b1;
    model.delete();
    do_op("read_after_rst", OP_READ, 64'h77, '0);

    // Random operations over a small key pool to exercise hits, misses, full.
    for (int n = 0; n < 150; n++) begin
      operation_e op;
      op = operation_e'($urandom_range(1, 3));
      do_op("rand", op, 64'($urandom_range(0, 11)), rand_val());
      for (int w = $urandom_range(0, 2); w > 0; w--) @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
